// File: rtl/cache_da_ring_buf.sv
// Ring-side ingress buffer in front of the cache debug-access engine.
// AR, AW and W are queued independently, AW is paired with W, reads and
// writes share the engine round-robin, and R/B come back through
// one-entry register slices.

package oursring_pkg;
    typedef struct packed {
        logic [5:0]  arid;
        logic [31:0] araddr;
    } oursring_req_if_ar_t;

    typedef struct packed {
        logic [5:0]  awid;
        logic [31:0] awaddr;
    } oursring_req_if_aw_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
    } oursring_req_if_w_t;

    typedef struct packed {
        logic [5:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } oursring_resp_if_r_t;

    typedef struct packed {
        logic [5:0] bid;
        logic [1:0] bresp;
    } oursring_resp_if_b_t;
endpackage

// Small synchronous FIFO; the head is read combinationally so a granted
// request can be presented and held without a read-latency bubble.
module ring_buf_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    // Extra pointer MSB distinguishes full from empty on index equality.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign dout  = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer update with wrap-around.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
        end
    end
endmodule

// One-entry response register slice; may reload in the same cycle it drains.
module ring_buf_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic full_reg;
    logic load;

    assign in_ready  = !full_reg || out_ready;
    assign load      = in_valid && in_ready;
    assign out_valid = full_reg;

    // Occupancy and payload capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 1'b0;
            out_data <= '0;
        end else begin
            full_reg <= load || (full_reg && !out_ready);
            if (load) out_data <= in_data;
        end
    end
endmodule

module cache_da_ring_buf
    import oursring_pkg::*;
#(
    parameter int AR_DEPTH = 2,
    parameter int AW_DEPTH = 2,
    parameter int W_DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_arvalid,
    output logic                up_arready,
    input  oursring_req_if_ar_t up_ar,
    input  logic                up_awvalid,
    output logic                up_awready,
    input  oursring_req_if_aw_t up_aw,
    input  logic                up_wvalid,
    output logic                up_wready,
    input  oursring_req_if_w_t  up_w,
    output logic                up_rvalid,
    input  logic                up_rready,
    output oursring_resp_if_r_t up_r,
    output logic                up_bvalid,
    input  logic                up_bready,
    output oursring_resp_if_b_t up_b,
    output logic                dn_arvalid,
    input  logic                dn_arready,
    output oursring_req_if_ar_t dn_ar,
    output logic                dn_awvalid,
    input  logic                dn_awready,
    output oursring_req_if_aw_t dn_aw,
    output logic                dn_wvalid,
    input  logic                dn_wready,
    output oursring_req_if_w_t  dn_w,
    input  logic                dn_rvalid,
    output logic                dn_rready,
    input  oursring_resp_if_r_t dn_r,
    input  logic                dn_bvalid,
    output logic                dn_bready,
    input  oursring_resp_if_b_t dn_b,
    output logic                busy
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_WR, ARB_RD} arb_state_t;

    arb_state_t state_reg, state_next;
    logic last_wr_reg, last_wr_next;
    logic aw_done_reg, aw_done_next;
    logic w_done_reg, w_done_next;

    logic ar_full, ar_empty, aw_full, aw_empty, w_full, w_empty;
    logic ar_pop, aw_pop, w_pop;
    logic wr_cand, rd_cand;

    // Ring sees no ready while reset is held.
    assign up_arready = !ar_full && !rst;
    assign up_awready = !aw_full && !rst;
    assign up_wready  = !w_full && !rst;

    ring_buf_fifo #(.DEPTH(AR_DEPTH), .WIDTH($bits(oursring_req_if_ar_t))) u_ar_fifo (
        .clk(clk), .rst(rst), .push(up_arvalid && up_arready), .din(up_ar),
        .pop(ar_pop), .dout(dn_ar), .full(ar_full), .empty(ar_empty)
    );
    ring_buf_fifo #(.DEPTH(AW_DEPTH), .WIDTH($bits(oursring_req_if_aw_t))) u_aw_fifo (
        .clk(clk), .rst(rst), .push(up_awvalid && up_awready), .din(up_aw),
        .pop(aw_pop), .dout(dn_aw), .full(aw_full), .empty(aw_empty)
    );
    ring_buf_fifo #(.DEPTH(W_DEPTH), .WIDTH($bits(oursring_req_if_w_t))) u_w_fifo (
        .clk(clk), .rst(rst), .push(up_wvalid && up_wready), .din(up_w),
        .pop(w_pop), .dout(dn_w), .full(w_full), .empty(w_empty)
    );

    assign wr_cand = !aw_empty && !w_empty;
    assign rd_cand = !ar_empty;

    // Arbiter state, fairness bit and write-half completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ARB_IDLE;
            last_wr_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_wr_reg <= last_wr_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    // Grant selection and downstream handshake; a grant is held until done.
    always_comb begin
        state_next   = state_reg;
        last_wr_next = last_wr_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        dn_arvalid   = 1'b0;
        dn_awvalid   = 1'b0;
        dn_wvalid    = 1'b0;
        ar_pop       = 1'b0;
        aw_pop       = 1'b0;
        w_pop        = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (wr_cand && rd_cand) begin
                    state_next = last_wr_reg ? ARB_RD : ARB_WR;
                end else if (wr_cand) begin
                    state_next = ARB_WR;
                end else if (rd_cand) begin
                    state_next = ARB_RD;
                end
            end
            ARB_WR: begin
                dn_awvalid = !aw_done_reg;
                dn_wvalid  = !w_done_reg;
                aw_pop     = dn_awvalid && dn_awready;
                w_pop      = dn_wvalid && dn_wready;
                if ((aw_done_reg || aw_pop) && (w_done_reg || w_pop)) begin
                    state_next   = ARB_IDLE;
                    last_wr_next = 1'b1;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else begin
                    aw_done_next = aw_done_reg || aw_pop;
                    w_done_next  = w_done_reg || w_pop;
                end
            end
            ARB_RD: begin
                dn_arvalid = 1'b1;
                if (dn_arready) begin
                    ar_pop       = 1'b1;
                    state_next   = ARB_IDLE;
                    last_wr_next = 1'b0;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    ring_buf_slice #(.WIDTH($bits(oursring_resp_if_r_t))) u_r_slice (
        .clk(clk), .rst(rst), .in_valid(dn_rvalid), .in_ready(dn_rready), .in_data(dn_r),
        .out_valid(up_rvalid), .out_ready(up_rready), .out_data(up_r)
    );
    ring_buf_slice #(.WIDTH($bits(oursring_resp_if_b_t))) u_b_slice (
        .clk(clk), .rst(rst), .in_valid(dn_bvalid), .in_ready(dn_bready), .in_data(dn_b),
        .out_valid(up_bvalid), .out_ready(up_bready), .out_data(up_b)
    );

    assign busy = !ar_empty || !aw_empty || !w_empty || up_rvalid || up_bvalid ||
                  (state_reg != ARB_IDLE);
endmodule

// File: tb/tb_cache_da_ring_buf.sv
// Directed bench for cache_da_ring_buf: a per-cycle vector table for a
// single read and a split write, then hand-written multi-cycle sequences.
module tb_cache_da_ring_buf;
    import oursring_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic up_arvalid, up_arready, up_awvalid, up_awready, up_wvalid, up_wready;
    logic up_rvalid, up_rready, up_bvalid, up_bready;
    logic dn_arvalid, dn_arready, dn_awvalid, dn_awready, dn_wvalid, dn_wready;
    logic dn_rvalid, dn_rready, dn_bvalid, dn_bready, busy;
    oursring_req_if_ar_t up_ar, dn_ar;
    oursring_req_if_aw_t up_aw, dn_aw;
    oursring_req_if_w_t  up_w, dn_w;
    oursring_resp_if_r_t up_r, dn_r;
    oursring_resp_if_b_t up_b, dn_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_da_ring_buf #(.AR_DEPTH(2), .AW_DEPTH(2), .W_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .up_arvalid(up_arvalid), .up_arready(up_arready), .up_ar(up_ar),
        .up_awvalid(up_awvalid), .up_awready(up_awready), .up_aw(up_aw),
        .up_wvalid(up_wvalid), .up_wready(up_wready), .up_w(up_w),
        .up_rvalid(up_rvalid), .up_rready(up_rready), .up_r(up_r),
        .up_bvalid(up_bvalid), .up_bready(up_bready), .up_b(up_b),
        .dn_arvalid(dn_arvalid), .dn_arready(dn_arready), .dn_ar(dn_ar),
        .dn_awvalid(dn_awvalid), .dn_awready(dn_awready), .dn_aw(dn_aw),
        .dn_wvalid(dn_wvalid), .dn_wready(dn_wready), .dn_w(dn_w),
        .dn_rvalid(dn_rvalid), .dn_rready(dn_rready), .dn_r(dn_r),
        .dn_bvalid(dn_bvalid), .dn_bready(dn_bready), .dn_b(dn_b),
        .busy(busy)
    );

    // One table row = inputs for one cycle plus the outputs expected in it.
    // exp = {up_arready, up_awready, up_wready, dn_arvalid, dn_awvalid,
    //        dn_wvalid, up_rvalid, up_bvalid, busy}
    typedef struct {
        logic       arv;
        logic       awv;
        logic       wv;
        logic [5:0] id;
        logic       dar;
        logic       daw;
        logic       dw;
        logic       drv;
        logic       dbv;
        logic [5:0] rid;
        logic       urr;
        logic       ubr;
        logic [8:0] exp;
        logic [5:0] exp_id;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    function automatic logic [31:0] addr_of(input logic [5:0] id);
        return 32'h1000_0000 | ({26'h0, id} << 4);
    endfunction

    function automatic logic [31:0] wdata_of(input logic [5:0] id);
        return 32'hA5A5_0000 | {26'h0, id};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] flags();
        return {up_arready, up_awready, up_wready, dn_arvalid, dn_awvalid,
                dn_wvalid, up_rvalid, up_bvalid, busy};
    endfunction

    task automatic clear_inputs();
        up_arvalid = 0; up_awvalid = 0; up_wvalid = 0;
        dn_arready = 0; dn_awready = 0; dn_wready = 0;
        dn_rvalid = 0; dn_bvalid = 0; up_rready = 1; up_bready = 1;
        up_ar = '0; up_aw = '0; up_w = '0; dn_r = '0; dn_b = '0;
    endtask

    // Leaves the caller in the low phase of the first cycle after reset.
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic set_ar(input logic [5:0] id);
        up_ar = '{arid: id, araddr: addr_of(id)};
    endtask

    task automatic set_wr(input logic [5:0] id);
        up_aw = '{awid: id, awaddr: addr_of(id)};
        up_w  = '{wdata: wdata_of(id), wstrb: 4'hF, wlast: 1'b1};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int      n;
        int      overlap;
        logic    acc;
        logic    g_wr [4];
        logic [5:0] g_id [4];
        logic [5:0] ids [3];
        int      deliveries;

        //                arv awv wv id  dar daw dw drv dbv rid urr ubr  exp            exp_id
        vec[0]  = '{1'b1,1'b0,1'b0,6'd5, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_0, 6'd0};
        vec[1]  = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_1, 6'd0};
        vec[2]  = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_100_00_1, 6'd5};
        vec[3]  = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_100_00_1, 6'd5};
        vec[4]  = '{1'b0,1'b0,1'b0,6'd0, 1'b1,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_100_00_1, 6'd5};
        vec[5]  = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b1,1'b0,6'd5, 1'b1,1'b1, 9'b111_000_00_0, 6'd0};
        vec[6]  = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_10_1, 6'd5};
        vec[7]  = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_0, 6'd0};
        vec[8]  = '{1'b0,1'b1,1'b0,6'd9, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_0, 6'd0};
        vec[9]  = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_1, 6'd0};
        vec[10] = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_1, 6'd0};
        vec[11] = '{1'b0,1'b0,1'b1,6'd9, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_1, 6'd0};
        vec[12] = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_1, 6'd0};
        vec[13] = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b1,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_011_00_1, 6'd9};
        vec[14] = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b1, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_001_00_1, 6'd9};
        vec[15] = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b1,6'd9, 1'b1,1'b1, 9'b111_000_00_0, 6'd0};
        vec[16] = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_01_1, 6'd9};
        vec[17] = '{1'b0,1'b0,1'b0,6'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,6'd0, 1'b1,1'b1, 9'b111_000_00_0, 6'd0};

        rst = 1;
        clear_inputs();
        @(negedge clk);
        #1 check("rst_readies", {29'h0, up_arready, up_awready, up_wready}, 32'h0);
        @(negedge clk);
        rst = 0;
        #1 check("reset_state", {23'h0, flags()}, {23'h0, 9'b111_000_00_0});

        // Single read then split write, cycle by cycle.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            up_arvalid = vec[i].arv; up_awvalid = vec[i].awv; up_wvalid = vec[i].wv;
            set_ar(vec[i].id);
            set_wr(vec[i].id);
            dn_arready = vec[i].dar; dn_awready = vec[i].daw; dn_wready = vec[i].dw;
            dn_rvalid = vec[i].drv; dn_bvalid = vec[i].dbv;
            dn_r = '{rid: vec[i].rid, rdata: 32'hDEAD_BEEF, rresp: 2'b00, rlast: 1'b1};
            dn_b = '{bid: vec[i].rid, bresp: 2'b00};
            up_rready = vec[i].urr; up_bready = vec[i].ubr;
            #1;
            $display("vec %0d: flags=%b expected=%b", i, flags(), vec[i].exp);
            check($sformatf("vec%0d_flags", i), {23'h0, flags()}, {23'h0, vec[i].exp});
            if (vec[i].exp[5]) begin
                check($sformatf("vec%0d_arid", i), {26'h0, dn_ar.arid}, {26'h0, vec[i].exp_id});
                check($sformatf("vec%0d_araddr", i), dn_ar.araddr, addr_of(vec[i].exp_id));
            end
            if (vec[i].exp[4]) begin
                check($sformatf("vec%0d_awid", i), {26'h0, dn_aw.awid}, {26'h0, vec[i].exp_id});
                check($sformatf("vec%0d_awaddr", i), dn_aw.awaddr, addr_of(vec[i].exp_id));
            end
            if (vec[i].exp[3])
                check($sformatf("vec%0d_wdata", i), dn_w.wdata, wdata_of(vec[i].exp_id));
            if (vec[i].exp[2]) begin
                check($sformatf("vec%0d_rid", i), {26'h0, up_r.rid}, {26'h0, vec[i].exp_id});
                check($sformatf("vec%0d_rdata", i), up_r.rdata, 32'hDEAD_BEEF);
            end
            if (vec[i].exp[1])
                check($sformatf("vec%0d_bid", i), {26'h0, up_b.bid}, {26'h0, vec[i].exp_id});
        end

        // Contention: two reads and two writes queued with last_wr=0.
        do_reset();
        up_arvalid = 1; set_ar(6'd1);
        up_awvalid = 1; up_wvalid = 1; set_wr(6'd3);
        @(negedge clk);
        set_ar(6'd2); set_wr(6'd4);
        @(negedge clk);
        up_arvalid = 0; up_awvalid = 0; up_wvalid = 0;
        dn_arready = 1; dn_awready = 1; dn_wready = 1;
        n = 0; overlap = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (dn_arvalid && dn_awvalid) overlap++;
            if (dn_awvalid && dn_awready) begin
                check("cont_wdata_pair", dn_w.wdata, wdata_of(dn_aw.awid));
                g_wr[n] = 1'b1; g_id[n] = dn_aw.awid; n++;
                $display("grant WR id=%0d", dn_aw.awid);
            end else if (dn_arvalid && dn_arready) begin
                g_wr[n] = 1'b0; g_id[n] = dn_ar.arid; n++;
                $display("grant RD id=%0d", dn_ar.arid);
            end
            @(negedge clk);
        end
        check("cont_grants", n, 4);
        check("cont_overlap", overlap, 0);
        if (n == 4) begin
            check("cont_g0", {g_wr[0], g_id[0]}, {1'b1, 6'd3});
            check("cont_g1", {g_wr[1], g_id[1]}, {1'b0, 6'd1});
            check("cont_g2", {g_wr[2], g_id[2]}, {1'b1, 6'd4});
            check("cont_g3", {g_wr[3], g_id[3]}, {1'b0, 6'd2});
        end

        // Backpressure: AR FIFO fills after two accepts, then drains in order.
        do_reset();
        up_arvalid = 1; set_ar(6'd1);
        #1 check("bp_acc1", up_arready, 1);
        @(negedge clk);
        set_ar(6'd2);
        #1 check("bp_acc2", up_arready, 1);
        @(negedge clk);
        set_ar(6'd3);
        #1 check("bp_full", up_arready, 0);
        @(negedge clk);
        #1 check("bp_full_hold", up_arready, 0);
        dn_arready = 1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            acc = up_arvalid && up_arready;
            if (dn_arvalid && dn_arready) begin
                ids[n] = dn_ar.arid; n++;
                $display("drain RD id=%0d", dn_ar.arid);
            end
            if (n == 3) break;
            @(negedge clk);
            if (acc) up_arvalid = 0;
        end
        check("bp_count", n, 3);
        if (n == 3) begin
            check("bp_id0", {26'h0, ids[0]}, 1);
            check("bp_id1", {26'h0, ids[1]}, 2);
            check("bp_id2", {26'h0, ids[2]}, 3);
        end
        @(negedge clk);
        up_arvalid = 0;
        @(negedge clk);
        #1 check("bp_idle_busy", busy, 0);

        // Response stall: one load, then held; resume drains and reloads.
        @(negedge clk);
        clear_inputs();
        up_rready = 0; dn_rvalid = 1;
        dn_r = '{rid: 6'd7, rdata: 32'h1234_5678, rresp: 2'b00, rlast: 1'b1};
        #1 check("st_load_ready", dn_rready, 1);
        check("st_empty", up_rvalid, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dn_r = '{rid: 6'd8, rdata: 32'hCAFE_F00D, rresp: 2'b11, rlast: 1'b1};
            #1 check($sformatf("st_ready%0d", k), dn_rready, 0);
            check($sformatf("st_valid%0d", k), up_rvalid, 1);
            check($sformatf("st_rid%0d", k), {26'h0, up_r.rid}, 7);
            check($sformatf("st_rdata%0d", k), up_r.rdata, 32'h1234_5678);
        end
        deliveries = 0;
        @(negedge clk);
        up_rready = 1;
        #1 check("st_resume_ready", dn_rready, 1);
        check("st_deliver_rid7", {25'h0, up_rvalid, up_r.rid}, {25'h0, 1'b1, 6'd7});
        if (up_rvalid) deliveries++;
        $display("deliver R id=%0d", up_r.rid);
        @(negedge clk);
        dn_rvalid = 0;
        #1 check("st_deliver_rid8", {25'h0, up_rvalid, up_r.rid}, {25'h0, 1'b1, 6'd8});
        check("st_decerr", {30'h0, up_r.rresp}, 3);
        check("st_rdata8", up_r.rdata, 32'hCAFE_F00D);
        if (up_rvalid) deliveries++;
        $display("deliver R id=%0d", up_r.rid);
        @(negedge clk);
        #1 if (up_rvalid) deliveries++;
        check("st_deliveries", deliveries, 2);

        // Reset while a write grant is held with FIFOs non-empty.
        do_reset();
        up_arvalid = 1; set_ar(6'd6);
        up_awvalid = 1; up_wvalid = 1; set_wr(6'd5);
        @(negedge clk);
        up_arvalid = 0; up_awvalid = 0; up_wvalid = 0;
        @(negedge clk);
        #1 check("mo_wr_grant", {30'h0, dn_awvalid, dn_arvalid}, 2);
        rst = 1;
        #1 check("mo_rst_ready", {29'h0, up_arready, up_awready, up_wready}, 0);
        @(negedge clk);
        rst = 0;
        #1 check("mo_after_rst", {23'h0, flags()}, {23'h0, 9'b111_000_00_0});
        up_arvalid = 1; set_ar(6'd12); dn_arready = 1; dn_awready = 1; dn_wready = 1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            acc = up_arvalid && up_arready;
            if (dn_awvalid) n = n + 100;
            if (dn_arvalid && dn_arready) begin
                check("mo_new_id", {26'h0, dn_ar.arid}, 12);
                $display("post-reset RD id=%0d", dn_ar.arid);
                n++;
                break;
            end
            @(negedge clk);
            if (acc) up_arvalid = 0;
        end
        check("mo_new_done", n, 1);
        @(negedge clk);
        #1 check("mo_busy_clear", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_da_ring_buf.md
Name: cache_da_ring_buf

Overview:
- Ring-side ingress buffer that sits directly upstream of the cache debug-access engine (cache_da_rw).
- Decouples the OURS ring station from that engine:
  - queues AR, AW and W independently;
  - pairs AW with W;
  - arbitrates reads vs writes round-robin (the engine alone would starve reads);
  - presents exactly one request at a time with stable valid.
- R and B responses return through one-entry register slices.

Parameters:
- AR_DEPTH, 2, AR FIFO entries (power of two, >=2)
- AW_DEPTH, 2, AW FIFO entries (power of two, >=2)
- W_DEPTH, 2, W FIFO entries (power of two, >=2)

Ports:
- clk  in  1  sole clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- up_arvalid/up_arready  in/out  1/1  ring AR handshake
- up_ar  in  oursring_req_if_ar_t  ring AR payload
- up_awvalid/up_awready  in/out  1/1  ring AW handshake
- up_aw  in  oursring_req_if_aw_t  ring AW payload
- up_wvalid/up_wready  in/out  1/1  ring W handshake
- up_w  in  oursring_req_if_w_t  ring W payload
- up_rvalid/up_rready  out/in  1/1  ring R handshake
- up_r  out  oursring_resp_if_r_t  ring R payload
- up_bvalid/up_bready  out/in  1/1  ring B handshake
- up_b  out  oursring_resp_if_b_t  ring B payload
- dn_ar*, dn_aw*, dn_w*  out/in  same types  request side to cache_da_rw
- dn_r*, dn_b*  in/out  same types  response side from cache_da_rw
- busy  out  1  any FIFO or slice non-empty, or grant held

Behaviour:
- Reset (rst=1 at posedge):
  - all FIFOs and slices empty; arbiter to ARB_IDLE; last_wr=0.
  - All valid outputs and busy are 0 during the cycle after reset.
  - up_*ready are 0 while rst=1 and are 1 from the first cycle after rst deasserts.
  - Reset mid-transaction discards queued and in-flight state; rst must be asserted together with the downstream block's reset.
- Ingress FIFOs:
  - up_Xready = !full_X; push on valid&ready.
  - An entry is visible to the arbiter the cycle after the push; there is no fall-through.
  - Push and pop in the same cycle are legal at any occupancy; a simultaneous push and pop while full is not possible, since ready=0.
  - Pointers are log2(DEPTH)+1 bits, wrap-around, with an MSB flip for full.
- Candidates: wr_cand = !empty_aw & !empty_w; rd_cand = !empty_ar.
- Arbiter FSM states: ARB_IDLE, ARB_WR, ARB_RD.
  - ARB_IDLE: if both candidates, go to ARB_WR when last_wr=0, else ARB_RD. If only one candidate, go to that state. Otherwise stay.
  - ARB_WR:
    - dn_awvalid = dn_wvalid = 1, driven with the FIFO heads.
    - AW pops on dn_awready and W pops on dn_wready. Each is latched in aw_done/w_done, and the corresponding valid drops after its handshake.
    - When both are done (same cycle or later): go to ARB_IDLE, set last_wr=1, clear the done flags.
  - ARB_RD: dn_arvalid=1; on dn_arready pop AR, go to ARB_IDLE, set last_wr=0.
  - Valid and payload are held stable until the handshake; dn_arvalid and dn_awvalid are never high together.
- Latency:
  - Upstream accept at cycle 0 -> dn valid at cycle 2 minimum.
  - After a downstream handshake, the next grant's dn valid appears 2 cycles later (one ARB_IDLE cycle).
- Response slices (R and B identical):
  - One-entry register.
  - dn_Xready = !full | up_Xready.
  - Load on dn valid&ready; up valid = full.
  - Simultaneous drain and load keeps the slice full with the new data.
  - Payload passes unmodified: rid/bid, rresp/bresp (including DECERR), rlast and rdata.
  - One cycle of added latency.
- No reordering: requests leave in arbiter order. Responses are not matched against requests (the downstream block is single-outstanding).
- busy is combinational from state.

Test Plan:
- Single read: AR araddr=0x..., arid=5 at cycle 0 -> dn_arvalid at cycle 2; dn_arready at cycle 4 -> pop; dn_r rid=5 rdata=0xDEADBEEF -> up_r identical one cycle later; busy returns to 0.
- Split write: AW at cycle 0, W at cycle 3 -> dn_awvalid & dn_wvalid both rise at cycle 5, never earlier; B bid matches awid.
- Contention: preload 2 AR and 2 AW+W with last_wr=0 -> grant order WR, RD, WR, RD; dn_arvalid & dn_awvalid never both 1.
- Full/backpressure: hold dn_*ready=0 and push AR_DEPTH+1 reads -> up_arready=0 after 2 accepts; release -> FIFO drains in order, tids 1,2,3.
- Response stall: hold up_rready=0 for 5 cycles while dn_r is presented -> dn_rready=0 after one load, data stable; resume -> single delivery, no duplicate.
- Reset mid-op: assert rst while in ARB_WR with FIFOs non-empty -> next cycle all valids=0, busy=0; up_*ready=1 after rst deasserts; a new request completes normally.
